// File: rtl/tone_sequencer.sv
// Score-driven note sequencer: walks {end, note, dur} words, paces each note by a
// programmable tempo tick, and drives note index, gate and note-on to the tone datapath.
module tone_sequencer #(
    parameter int unsigned NOTE_W  = 6,
    parameter int unsigned DUR_W   = 4,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned TEMPO_W = 24
) (
    input  logic                      clk_i,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic                      loop_i,
    input  logic [TEMPO_W-1:0]        tempo_i,
    output logic [ADDR_W-1:0]         score_addr_o,
    input  logic [NOTE_W+DUR_W:0]     score_data_i,
    output logic [NOTE_W-1:0]         note_index_o,
    output logic                      gate_o,
    output logic                      note_on_o,
    output logic                      busy_o,
    output logic                      done_o
);

    typedef enum logic [1:0] {StIdle, StFetch, StPlay, StDone} state_e;

    state_e               r_state;
    logic [ADDR_W-1:0]    r_addr;
    logic [NOTE_W-1:0]    r_note;
    logic                 r_gate;
    logic                 r_note_on;
    logic                 r_busy;
    logic                 r_done;
    logic [DUR_W-1:0]     r_dur_cnt;
    logic [TEMPO_W-1:0]   r_tempo_cnt;
    logic [TEMPO_W-1:0]   r_tempo_period;

    logic                 w_end;
    logic [NOTE_W-1:0]    w_note;
    logic [DUR_W-1:0]     w_dur;
    logic [TEMPO_W-1:0]   w_tempo_m1;

    assign w_end  = score_data_i[NOTE_W+DUR_W];
    assign w_note = score_data_i[NOTE_W+DUR_W-1:DUR_W];
    assign w_dur  = score_data_i[DUR_W-1:0];
    // Period is stored as T-1; a tempo of 0 behaves like 1.
    assign w_tempo_m1 = (tempo_i == '0) ? '0 : tempo_i - TEMPO_W'(1);

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_state        <= StIdle;
            r_addr         <= '0;
            r_note         <= '0;
            r_gate         <= 1'b0;
            r_note_on      <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_dur_cnt      <= '0;
            r_tempo_cnt    <= '0;
            r_tempo_period <= '0;
        end else if (stop_i) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_note      <= '0;
            r_gate      <= 1'b0;
            r_note_on   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dur_cnt   <= '0;
            r_tempo_cnt <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    r_addr <= '0;
                    r_gate <= 1'b0;
                    if (start_i) begin
                        r_state <= StFetch;
                        r_busy  <= 1'b1;
                    end
                end
                StFetch: begin
                    if (w_end) begin
                        // End at address 0 always finishes so an empty loop cannot hang.
                        if (r_addr != '0 && loop_i) begin
                            r_addr <= '0;
                        end else begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                            r_gate  <= 1'b0;
                            r_note  <= '0;
                            r_addr  <= '0;
                        end
                    end else begin
                        r_note         <= w_note;
                        r_gate         <= (w_note != '0);
                        r_note_on      <= (w_note != '0);
                        r_dur_cnt      <= w_dur;
                        r_tempo_cnt    <= w_tempo_m1;
                        r_tempo_period <= w_tempo_m1;
                        r_state        <= StPlay;
                    end
                end
                StPlay: begin
                    r_note_on <= 1'b0;
                    if (r_tempo_cnt == '0) begin
                        r_tempo_cnt <= r_tempo_period;
                        if (r_dur_cnt != '0) begin
                            r_dur_cnt <= r_dur_cnt - DUR_W'(1);
                        end else begin
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_state <= StFetch;
                        end
                    end else begin
                        r_tempo_cnt <= r_tempo_cnt - TEMPO_W'(1);
                    end
                end
                StDone: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign score_addr_o = r_addr;
    assign note_index_o = r_note;
    assign gate_o       = r_gate;
    assign note_on_o    = r_note_on;
    assign busy_o       = r_busy;
    assign done_o       = r_done;

endmodule

// File: tb/tb_tone_sequencer.sv
// Self-checking bench for tone_sequencer: expected per-cycle output traces are built
// from the score rules (fetch cycle + (dur+1)*T play cycles per entry).
module tb_tone_sequencer;

    logic        clk_i = 1'b0;
    logic        rst;
    logic        start_i, stop_i, loop_i;
    logic [23:0] tempo_i;
    logic [4:0]  score_addr_o;
    logic [10:0] score_data_i;
    logic [5:0]  note_index_o;
    logic        gate_o, note_on_o, busy_o, done_o;

    logic [10:0] score_mem [32];
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [4:0] addr;
        logic [5:0] note;
        logic       gate;
        logic       on;
        logic       busy;
        logic       done;
        bit         chk_addr;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk_i = ~clk_i;
    assign score_data_i = score_mem[score_addr_o];

    tone_sequencer dut (
        .clk_i        (clk_i),
        .rst          (rst),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .loop_i       (loop_i),
        .tempo_i      (tempo_i),
        .score_addr_o (score_addr_o),
        .score_data_i (score_data_i),
        .note_index_o (note_index_o),
        .gate_o       (gate_o),
        .note_on_o    (note_on_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    function automatic logic [10:0] mk(input logic e, input logic [5:0] n, input logic [3:0] d);
        return {e, n, d};
    endfunction

    task automatic clear_score();
        for (int i = 0; i < 32; i++) score_mem[i] = mk(1'b1, 6'd0, 4'd0);
    endtask

    // Expected trace, one entry per cycle, starting with the first FETCH cycle.
    task automatic build_trace(input int max_cycles);
        int addr, t, n, dur;
        logic [5:0] pn, note;
        logic pg;
        logic [10:0] w;
        exp_q.delete();
        addr = 0; pn = '0; pg = 1'b0;
        t = (tempo_i == 0) ? 1 : int'(tempo_i);
        while (exp_q.size() < max_cycles) begin
            w = score_mem[addr];
            exp_q.push_back('{5'(addr), pn, pg, 1'b0, 1'b1, 1'b0, 1'b1});
            if (w[10]) begin
                if (addr != 0 && loop_i) begin
                    addr = 0;
                    continue;
                end
                exp_q.push_back('{5'd0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
                exp_q.push_back('{5'd0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
                break;
            end
            note = w[9:4];
            dur  = int'(w[3:0]);
            n = (dur + 1) * t;
            for (int i = 0; i < n; i++)
                exp_q.push_back('{5'(addr), note, note != 0, (i == 0) && (note != 0),
                                  1'b1, 1'b0, 1'b1});
            pn = note; pg = (note != 0);
            addr = (addr + 1) % 32;
        end
        while (exp_q.size() > max_cycles) void'(exp_q.pop_back());
    endtask

    task automatic play_and_compare(input string name, input int max_cycles);
        exp_t e;
        build_trace(max_cycles);
        start_i = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            e = exp_q[k];
            checks++;
            if ((e.chk_addr && score_addr_o !== e.addr) || note_index_o !== e.note ||
                gate_o !== e.gate || note_on_o !== e.on || busy_o !== e.busy ||
                done_o !== e.done) begin
                failures++;
                $display("FAIL %s cyc%0d: got addr=%0d note=%0d gate=%b on=%b busy=%b done=%b; want addr=%0d note=%0d gate=%b on=%b busy=%b done=%b",
                         name, k, score_addr_o, note_index_o, gate_o, note_on_o, busy_o, done_o,
                         e.addr, e.note, e.gate, e.on, e.busy, e.done);
            end
        end
        if (exp_q[exp_q.size()-1].busy) begin
            stop_i = 1'b1;
            @(posedge clk_i); #1;
            stop_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({score_addr_o, note_index_o, gate_o, note_on_o, busy_o, done_o} !== 15'd0) begin
            failures++;
            $display("FAIL reset: got addr=%0d note=%0d gate=%b on=%b busy=%b done=%b; want all 0",
                     score_addr_o, note_index_o, gate_o, note_on_o, busy_o, done_o);
        end
        @(negedge clk_i) rst = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic load_basic();
        clear_score();
        score_mem[0] = mk(1'b0, 6'd5, 4'd1);
        score_mem[1] = mk(1'b0, 6'd0, 4'd0);
        score_mem[2] = mk(1'b1, 6'd0, 4'd0);
    endtask

    task automatic test_basic();
        load_basic(); tempo_i = 24'd4; loop_i = 1'b0;
        play_and_compare("basic", 200);
    endtask

    task automatic test_loop();
        load_basic(); tempo_i = 24'd4; loop_i = 1'b1;
        play_and_compare("loop", 60);
        loop_i = 1'b0;
    endtask

    task automatic test_stop();
        load_basic(); tempo_i = 24'd4; loop_i = 1'b0;
        start_i = 1'b1;
        @(posedge clk_i); #1; start_i = 1'b0;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        stop_i = 1'b1;
        @(posedge clk_i); #1; stop_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({score_addr_o, note_index_o, gate_o, note_on_o, busy_o, done_o} !== 15'd0) begin
                failures++;
                $display("FAIL stop cyc%0d: got addr=%0d note=%0d gate=%b on=%b busy=%b done=%b; want all 0",
                         k, score_addr_o, note_index_o, gate_o, note_on_o, busy_o, done_o);
            end
            @(posedge clk_i); #1;
        end
        play_and_compare("replay_after_stop", 200);
    endtask

    task automatic test_tempo_zero();
        clear_score();
        score_mem[0] = mk(1'b0, 6'd3, 4'd0);
        score_mem[1] = mk(1'b0, 6'd3, 4'd0);
        tempo_i = 24'd0; loop_i = 1'b0;
        play_and_compare("tempo_zero", 200);
    endtask

    task automatic test_end_at_zero();
        clear_score(); tempo_i = 24'd2; loop_i = 1'b1;
        play_and_compare("end_at_zero_loop", 20);
        loop_i = 1'b0;
    endtask

    task automatic test_wrap();
        clear_score();
        for (int i = 0; i < 32; i++) score_mem[i] = mk(1'b0, 6'($urandom_range(0, 63)), 4'd0);
        tempo_i = 24'd1; loop_i = 1'b0;
        play_and_compare("wrap", 74);
    endtask

    task automatic test_random_scores();
        int len;
        for (int it = 0; it < 6; it++) begin
            clear_score();
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++)
                score_mem[i] = mk(1'b0, ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom_range(1, 63)),
                                  4'($urandom_range(0, 3)));
            tempo_i = 24'($urandom_range(0, 3));
            loop_i  = 1'($urandom_range(0, 1));
            play_and_compare($sformatf("random%0d", it), 120);
        end
        loop_i = 1'b0;
    endtask

    task automatic test_rst_mid_play();
        load_basic(); tempo_i = 24'd4; loop_i = 1'b0;
        start_i = 1'b1;
        repeat (4) begin @(posedge clk_i); #1; end
        rst = 1'b1; #1;
        checks++;
        if ({score_addr_o, note_index_o, gate_o, note_on_o, busy_o, done_o} !== 15'd0) begin
            failures++;
            $display("FAIL rst_immediate: got addr=%0d note=%0d gate=%b on=%b busy=%b done=%b; want all 0",
                     score_addr_o, note_index_o, gate_o, note_on_o, busy_o, done_o);
        end
        @(posedge clk_i); #3;
        rst = 1'b0;
        @(posedge clk_i); #1;
        checks++;
        if (busy_o !== 1'b1 || score_addr_o !== 5'd0 || note_on_o !== 1'b0 || gate_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_resume_fetch: got busy=%b addr=%0d on=%b gate=%b; want busy=1 addr=0 on=0 gate=0",
                     busy_o, score_addr_o, note_on_o, gate_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (note_on_o !== 1'b1 || note_index_o !== 6'd5 || gate_o !== 1'b1) begin
            failures++;
            $display("FAIL rst_resume_play: got on=%b note=%0d gate=%b; want on=1 note=5 gate=1",
                     note_on_o, note_index_o, gate_o);
        end
        start_i = 1'b0;
        stop_i = 1'b1;
        @(posedge clk_i); #1; stop_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; loop_i = 1'b0; tempo_i = '0;
        clear_score();
        test_reset();
        test_basic();
        test_loop();
        test_stop();
        test_tempo_zero();
        test_end_at_zero();
        test_wrap();
        test_random_scores();
        test_rst_mid_play();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
